serial_subtractor: RTL and testbench

//   Bit-serial multi-bit subtractor: computes DIFF = A - B - BIN over WIDTH clock cycles, LSB first.

---
 rtl/serial_subtractor.sv | 148 ++++++++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN over WIDTH cycles, LSB first, valid/ready on both sides.
// Optional build macro SERSUB_OVERFLOW_EN adds the two's-complement overflow flag on ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] fsub_step(input logic x, input logic y, input logic bi);
    fsub_step = {(~x & y) | (~x & bi) | (y & bi), x ^ y ^ bi};
  endfunction

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;

  logic [1:0]       step_s;
  logic [WIDTH-1:0] res_nxt_s;
  logic             load_s;
  logic             fin_s;

  // One subtractor step on the current LSBs; the new difference bit enters the result at the MSB.
  always_comb begin
    step_s    = fsub_step(a_sh_r[0], b_sh_r[0], br_r);
    res_nxt_s = WIDTH'({step_s[0], res_r} >> 1);
    load_s    = (state_r == IDLE) && in_valid && in_ready_r;
    fin_s     = (state_r == SHIFT) && (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Control FSM, operand shifters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      res_r       <= '0;
      br_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            a_sh_r     <= a;
            b_sh_r     <= b;
            br_r       <= bin;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end else begin
            state_r    <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          res_r  <= res_nxt_s;
          br_r   <= step_s[1];
          cnt_r  <= cnt_r + CNT_W'(1);
          if (fin_s) begin
            diff_r      <= res_nxt_s;
            bout_r      <= step_s[1];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= SHIFT;
          end
        end
        DONE: begin
          // Leaving DONE wins over any in_valid; new operands are taken from IDLE next edge.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;

`ifdef SERSUB_OVERFLOW_EN
  logic a_msb_r;
  logic b_msb_r;
  logic ovf_r;

  // Captures operand sign bits at load and evaluates signed overflow when the result completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (load_s) begin
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b[WIDTH-1];
      end
      if (fin_s) begin
        ovf_r <= (a_msb_r ^ b_msb_r) & (res_nxt_s[WIDTH-1] ^ a_msb_r);
      end
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: an 8-bit instance plus a 1-bit instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       bin8 = 1'b0;
  logic       in_ready8, out_valid8, bout8, ovf8;
  logic [7:0] diff8;
  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       bin1 = 1'b0;
  logic       in_ready1, out_valid1, bout1, ovf1;
  logic [0:0] diff1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  // Presents operands, waits for the accept edge, then counts edges until out_valid (bounded).
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, output int lat);
    a8 = ta; b8 = tb; bin8 = tbin; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    chk_cnt++;
    if ({out_valid8, diff8, bout8, ovf8} !== 11'd0) $display("FAIL reset_outputs got %h exp 000", {out_valid8, diff8, bout8, ovf8});
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (in_ready8 !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready8);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int lat;
    out_ready8 = 1'b1;
    run8(8'h35, 8'h12, 1'b0, lat);
    chk_cnt++;
    if (lat !== 8) $display("FAIL basic_latency got %0d exp 8", lat);
    else pass_cnt++;
    chk_cnt++;
    if ({diff8, bout8} !== {8'h23, 1'b0}) $display("FAIL basic_result got %h/%b exp 23/0", diff8, bout8);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready8 !== 1'b0) $display("FAIL basic_busy got %b exp 0", in_ready8);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({in_ready8, out_valid8} !== 2'b10) $display("FAIL basic_ready_back got %b exp 10", {in_ready8, out_valid8});
    else pass_cnt++;
  endtask

  task automatic test_borrow;
    int lat;
    run8(8'h00, 8'h01, 1'b0, lat);
    chk_cnt++;
    if ({diff8, bout8} !== {8'hFF, 1'b1}) $display("FAIL borrow_0m1 got %h/%b exp ff/1", diff8, bout8);
    else pass_cnt++;
    @(posedge clk); #1;
    run8(8'h00, 8'h00, 1'b1, lat);
    chk_cnt++;
    if ({diff8, bout8} !== {8'hFF, 1'b1}) $display("FAIL borrow_bin got %h/%b exp ff/1", diff8, bout8);
    else pass_cnt++;
    @(posedge clk); #1;
    run8(8'hA7, 8'hA7, 1'b0, lat);
    chk_cnt++;
    if ({diff8, bout8} !== {8'h00, 1'b0}) $display("FAIL equal_ops got %h/%b exp 00/0", diff8, bout8);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int   lat;
    logic exp_ovf;
`ifdef SERSUB_OVERFLOW_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    run8(8'h80, 8'h01, 1'b0, lat);
    chk_cnt++;
    if ({diff8, ovf8} !== {8'h7F, exp_ovf}) $display("FAIL ovf_80m01 got %h/%b exp 7f/%b", diff8, ovf8, exp_ovf);
    else pass_cnt++;
    @(posedge clk); #1;
    run8(8'h10, 8'h01, 1'b0, lat);
    chk_cnt++;
    if ({diff8, ovf8} !== {8'h0F, 1'b0}) $display("FAIL ovf_10m01 got %h/%b exp 0f/0", diff8, ovf8);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready8 = 1'b0;
    run8(8'h5A, 8'h3C, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; in_valid8 = 1'b1;
      chk_cnt++;
      if ({out_valid8, in_ready8, diff8, bout8} !== {1'b1, 1'b0, 8'h1D, 1'b0})
        $display("FAIL bp_hold cycle %0d got %b%b/%h/%b exp 10/1d/0", i, out_valid8, in_ready8, diff8, bout8);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({out_valid8, in_ready8} !== 2'b01) $display("FAIL bp_release got %b exp 01", {out_valid8, in_ready8});
    else pass_cnt++;
    repeat (10) @(posedge clk);
    #1;
    chk_cnt++;
    if ({out_valid8, in_ready8, diff8} !== {2'b01, 8'h1D}) $display("FAIL bp_ignored got %b/%h exp 01/1d", {out_valid8, in_ready8}, diff8);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop;
    int lat;
    a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({out_valid8, diff8, bout8, ovf8} !== 11'd0) $display("FAIL midop_reset got %h exp 000", {out_valid8, diff8, bout8, ovf8});
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk_cnt++;
    if ({in_ready8, out_valid8} !== 2'b10) $display("FAIL midop_idle got %b exp 10", {in_ready8, out_valid8});
    else pass_cnt++;
    run8(8'h0A, 8'h03, 1'b0, lat);
    chk_cnt++;
    if ({lat, diff8, bout8} !== {32'd8, 8'h07, 1'b0}) $display("FAIL midop_next got %0d/%h/%b exp 8/07/0", lat, diff8, bout8);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    run8(8'h44, 8'h22, 1'b0, lat);
    chk_cnt++;
    if (diff8 !== 8'h22) $display("FAIL b2b_first got %h exp 22", diff8);
    else pass_cnt++;
    a8 = 8'h09; b8 = 8'h05; bin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({in_ready8, out_valid8} !== 2'b10) $display("FAIL b2b_priority got %b exp 10", {in_ready8, out_valid8});
    else pass_cnt++;
    run8(8'h09, 8'h05, 1'b0, lat);
    chk_cnt++;
    if ({lat, diff8} !== {32'd8, 8'h04}) $display("FAIL b2b_second got %0d/%h exp 8/04", lat, diff8);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_width1;
    logic [7:0] d_tab;
    logic [7:0] b_tab;
    int         lat;
    d_tab = 8'b1001_0110;
    b_tab = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); bin1 = 1'(i); in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk_cnt++;
      if ({lat, diff1, bout1} !== {32'd1, d_tab[i], b_tab[i]})
        $display("FAIL w1_case%0d got %0d/%b/%b exp 1/%b/%b", i, lat, diff1, bout1, d_tab[i], b_tab[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_width1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
